// File: rtl/imem_access_arbiter.sv
// Instruction-memory port arbiter: the core fetch and the loader/debug port share one port; the core is stalled until boot completes.
// Optional macro IMEM_WRITE_PROTECT_EN adds ld_err and blocks loader writes while in RUN.
module imem_access_arbiter #(
  parameter int INS_ADDRESS  = 9,
  parameter int INS_W        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic [INS_ADDRESS-1:0] fetch_addr,
  output logic                   fetch_stall,
  output logic                   fetch_valid,
  output logic [INS_W-1:0]       fetch_data,
  input  logic                   ld_req,
  input  logic                   ld_we,
  input  logic [INS_ADDRESS-1:0] ld_addr,
  input  logic [INS_W-1:0]       ld_wdata,
  input  logic                   boot_done,
  output logic                   ld_gnt,
  output logic                   ld_rvalid,
  output logic [INS_W-1:0]       ld_rdata,
`ifdef IMEM_WRITE_PROTECT_EN
  output logic                   ld_err,
`endif
  output logic [INS_ADDRESS-1:0] mem_addr,
  output logic                   mem_we,
  output logic [INS_W-1:0]       mem_wdata,
  input  logic [INS_W-1:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {BOOT, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_gnt;
  logic             wp_block;

`ifdef IMEM_WRITE_PROTECT_EN
  assign wp_block = (state == RUN);
`else
  assign wp_block = 1'b0;
`endif

  // Grant decision: fetch wins in RUN unless the loader has waited STARVE_LIMIT cycles.
  always_comb begin
    fetch_gnt   = 1'b0;
    ld_gnt      = 1'b0;
    fetch_stall = 1'b1;
    if (state == BOOT) begin
      ld_gnt = ld_req;
    end else if (ld_req && (!fetch_req || starve_cnt == CNT_LIMIT)) begin
      ld_gnt      = 1'b1;
      fetch_stall = fetch_req;
    end else begin
      fetch_gnt   = fetch_req;
      fetch_stall = 1'b0;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr;
      mem_we    = ld_we & ~wp_block;
      mem_wdata = ld_wdata;
    end
  end

  // Read return stage: memory data captured at the grant edge, valid one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BOOT;
      starve_cnt  <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      ld_rvalid   <= 1'b0;
      ld_rdata    <= '0;
`ifdef IMEM_WRITE_PROTECT_EN
      ld_err      <= 1'b0;
`endif
    end else begin
      if (state == BOOT && boot_done)
        state <= RUN;
      if (state == RUN && fetch_gnt && ld_req)
        starve_cnt <= starve_cnt + CNT_W'(1);
      else
        starve_cnt <= '0;
      fetch_valid <= fetch_gnt;
      if (fetch_gnt)
        fetch_data <= mem_rdata;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (ld_gnt && !ld_we)
        ld_rdata <= mem_rdata;
`ifdef IMEM_WRITE_PROTECT_EN
      ld_err <= ld_gnt & ld_we & wp_block;
`endif
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed bench for imem_access_arbiter with a behavioural instruction memory.
// Honours IMEM_WRITE_PROTECT_EN when the design is built with it.
module tb_imem_access_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          boot_done;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
`ifdef IMEM_WRITE_PROTECT_EN
  logic          ld_err;
`endif
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  imem_access_arbiter #(.INS_ADDRESS(AW), .INS_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .boot_done(boot_done), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
`ifdef IMEM_WRITE_PROTECT_EN
    .ld_err(ld_err),
`endif
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_wdata = '0; boot_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fetch_valid got=%b want=0", fetch_valid); end
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL reset_ld_rvalid got=%b want=0", ld_rvalid); end
    total++; if (fetch_data !== 32'h0) begin bad++; $display("FAIL reset_fetch_data got=%h want=0", fetch_data); end
    total++; if (ld_rdata !== 32'h0) begin bad++; $display("FAIL reset_ld_rdata got=%h want=0", ld_rdata); end
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", fetch_stall); end
  endtask

  task automatic boot_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    #1;
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL boot_stall got=%b want=1", fetch_stall); end
    total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL boot_ld_gnt got=%b want=1", ld_gnt); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL boot_mem_we got=%b want=1", mem_we); end
    total++; if (mem_addr !== a) begin bad++; $display("FAIL boot_mem_addr got=%0d want=%0d", mem_addr, a); end
    total++; if (mem_wdata !== d) begin bad++; $display("FAIL boot_mem_wdata got=%h want=%h", mem_wdata, d); end
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fetch_valid got=%b want=0", fetch_valid); end
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL boot_write_rvalid got=%b want=0", ld_rvalid); end
  endtask

  task automatic test_boot_hold();
    @(negedge clk);
    reset = 1'b1; fetch_req = 1'b1; fetch_addr = 9'd3;
    boot_write(9'd3, 32'h00500093);
    boot_write(9'd6, 32'h00A00113);
    @(negedge clk);
    ld_req = 1'b0; ld_we = 1'b0;
    #1;
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL boot_idle_stall got=%b want=1", fetch_stall); end
    total++; if (mem_we !== 1'b0 || mem_addr !== 9'd0) begin bad++; $display("FAIL boot_idle_mem got=%b/%0d want=0/0", mem_we, mem_addr); end
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_idle_fetch_valid got=%b want=0", fetch_valid); end
  endtask

  task automatic fetch_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a;
    #1;
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall got=%b want=0", fetch_stall); end
    total++; if (mem_addr !== a || mem_we !== 1'b0) begin bad++; $display("FAIL fetch_mem got=%0d/%b want=%0d/0", mem_addr, mem_we, a); end
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b want=1", fetch_valid); end
    total++; if (fetch_data !== d) begin bad++; $display("FAIL fetch_data got=%h want=%h", fetch_data, d); end
  endtask

  task automatic test_boot_exit();
    @(negedge clk);
    boot_done = 1'b1; fetch_req = 1'b1; fetch_addr = 9'd3;
    #1;
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL exit_stall got=%b want=1", fetch_stall); end
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL exit_fetch_valid got=%b want=0", fetch_valid); end
    @(negedge clk);
    boot_done = 1'b0;
    fetch_one(9'd3, 32'h00500093);
    fetch_one(9'd6, 32'h00A00113);
  endtask

  task automatic test_starvation();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 9'd3;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'd6;
    for (int rep = 0; rep < 2; rep++) begin
      for (int cyc = 0; cyc < 5; cyc++) begin
        #1;
        total++; if (ld_gnt !== (cyc == 4)) begin bad++; $display("FAIL starve_ld_gnt r%0d c%0d got=%b want=%b", rep, cyc, ld_gnt, cyc == 4); end
        total++; if (fetch_stall !== (cyc == 4)) begin bad++; $display("FAIL starve_stall r%0d c%0d got=%b want=%b", rep, cyc, fetch_stall, cyc == 4); end
        total++; if (mem_addr !== ((cyc == 4) ? 9'd6 : 9'd3)) begin bad++; $display("FAIL starve_mem_addr r%0d c%0d got=%0d", rep, cyc, mem_addr); end
        @(posedge clk); #1;
        total++; if (fetch_valid !== (cyc != 4)) begin bad++; $display("FAIL starve_fetch_valid r%0d c%0d got=%b want=%b", rep, cyc, fetch_valid, cyc != 4); end
        total++; if (ld_rvalid !== (cyc == 4)) begin bad++; $display("FAIL starve_ld_rvalid r%0d c%0d got=%b want=%b", rep, cyc, ld_rvalid, cyc == 4); end
        if (cyc == 4) begin
          total++; if (ld_rdata !== 32'h00A00113) begin bad++; $display("FAIL starve_ld_rdata got=%h want=00a00113", ld_rdata); end
        end
        @(negedge clk);
      end
    end
    fetch_req = 1'b0; ld_req = 1'b0;
  endtask

  task automatic test_loader_only();
    @(negedge clk);
    fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'd3;
    #1;
    total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL ldonly_gnt got=%b want=1", ld_gnt); end
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL ldonly_stall got=%b want=0", fetch_stall); end
    @(posedge clk); #1;
    total++; if (ld_rvalid !== 1'b1) begin bad++; $display("FAIL ldonly_rvalid got=%b want=1", ld_rvalid); end
    total++; if (ld_rdata !== 32'h00500093) begin bad++; $display("FAIL ldonly_rdata got=%h want=00500093", ld_rdata); end
    @(negedge clk);
    ld_req = 1'b0;
    @(posedge clk); #1;
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL ldonly_rvalid_drop got=%b want=0", ld_rvalid); end
    total++; if (ld_rdata !== 32'h00500093) begin bad++; $display("FAIL ldonly_rdata_hold got=%h want=00500093", ld_rdata); end
  endtask

  task automatic test_run_write();
    logic [DW-1:0] expect_data;
    @(negedge clk);
    fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'd3; ld_wdata = 32'hFFFFFFFF;
    #1;
    total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL runwr_gnt got=%b want=1", ld_gnt); end
`ifdef IMEM_WRITE_PROTECT_EN
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL runwr_mem_we got=%b want=0", mem_we); end
    expect_data = 32'h00500093;
`else
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL runwr_mem_we got=%b want=1", mem_we); end
    expect_data = 32'hFFFFFFFF;
`endif
    @(posedge clk); #1;
    total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL runwr_rvalid got=%b want=0", ld_rvalid); end
`ifdef IMEM_WRITE_PROTECT_EN
    total++; if (ld_err !== 1'b1) begin bad++; $display("FAIL runwr_ld_err got=%b want=1", ld_err); end
`endif
    @(negedge clk);
    ld_req = 1'b0; ld_we = 1'b0;
    fetch_one(9'd3, expect_data);
    @(negedge clk);
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 9'd6; reset = 1'b0;
    #1;
    total++; if (fetch_stall !== 1'b0) begin bad++; $display("FAIL rstmid_pre_stall got=%b want=0", fetch_stall); end
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rstmid_fetch_valid got=%b want=0", fetch_valid); end
    total++; if (fetch_data !== 32'h0) begin bad++; $display("FAIL rstmid_fetch_data got=%h want=0", fetch_data); end
    total++; if (fetch_stall !== 1'b1) begin bad++; $display("FAIL rstmid_stall got=%b want=1", fetch_stall); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1) begin bad++; $display("FAIL rstmid_boot_hold got=%b/%b want=0/1", fetch_valid, fetch_stall); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_boot_hold();
    test_boot_exit();
    test_starvation();
    test_loader_only();
    test_run_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Sits between the core fetch path and the instructionmemory block.
- Shares the single instruction-memory port between two requesters:
  - core fetch (PC-driven, read only);
  - program loader/debug port (read and write).
- Owns the boot sequence: holds the core stalled until the loader signals that program load is complete.
- During run, fetch has priority; a starvation counter guarantees forward progress for the loader.

Parameters:
- INS_ADDRESS, 9, instruction-memory address width (word address).
- INS_W, 32, instruction word width.
- STARVE_LIMIT, 4, consecutive RUN cycles a loader request may be blocked before it is force-granted (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- fetch_req  in  1  core requests an instruction read.
- fetch_addr  in  INS_ADDRESS  fetch word address.
- fetch_stall  out  1  core must hold PC and fetch_addr this cycle.
- fetch_valid  out  1  fetch_data valid (one cycle after the granted fetch).
- fetch_data  out  INS_W  fetched instruction.
- ld_req  in  1  loader access request.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  INS_ADDRESS  loader word address.
- ld_wdata  in  INS_W  loader write data.
- boot_done  in  1  single-cycle pulse: program load finished.
- ld_gnt  out  1  loader access performed this cycle.
- ld_rvalid  out  1  ld_rdata valid (one cycle after a granted loader read).
- ld_rdata  out  INS_W  loader read data.
- mem_addr  out  INS_ADDRESS  address to instruction memory.
- mem_we  out  1  write enable to instruction memory.
- mem_wdata  out  INS_W  write data to instruction memory.
- mem_rdata  in  INS_W  combinational read data from instruction memory.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state = BOOT, starve_cnt = 0.
  - fetch_valid, ld_rvalid = 0.
  - fetch_data, ld_rdata = 0.
  - reset overrides boot_done and all requests in the same cycle.
  - Reset mid-access aborts the access: no valid pulse follows.
- State BOOT:
  - fetch_stall = 1; fetch_req is ignored.
  - ld_gnt = ld_req.
  - boot_done pulse → RUN at the next edge. A loader access in that same cycle is still performed.
- State RUN, per-cycle grant (combinational from state and requests):
  - Only fetch_req: fetch granted, fetch_stall = 0.
  - Only ld_req: loader granted, fetch_stall = 0.
  - Both, and starve_cnt < STARVE_LIMIT: fetch granted, ld_gnt = 0, starve_cnt increments.
  - Both, and starve_cnt == STARVE_LIMIT: loader granted, fetch_stall = 1, starve_cnt cleared.
  - starve_cnt clears whenever the loader is granted or ld_req == 0.
  - boot_done is ignored in RUN.
- Memory port:
  - Addr/we/wdata are muxed combinationally from the granted requester.
  - mem_we = ld_we & ld_gnt only; fetch never writes.
  - With no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Read return (latency 1 cycle):
  - mem_rdata is registered into fetch_data or ld_rdata at the grant edge.
  - The matching valid is high for exactly one cycle after it.
  - Data registers hold their value when not updated.
  - A loader write produces no ld_rvalid.
- Fetch_stall is combinational. The core must keep fetch_req and fetch_addr stable while fetch_stall is high.
- Back-to-back: a new grant is allowed every cycle; no idle cycle is inserted between requesters.

Optional Feature:
- IMEM_WRITE_PROTECT_EN
- Defined:
  - Adds output port ld_err (1 bit, reset 0).
  - In RUN, a granted loader write is suppressed (mem_we = 0) and ld_err pulses high one cycle later.
  - Loader reads in RUN and all loader writes in BOOT are unaffected.
- Undefined:
  - No ld_err port.
  - Loader writes are performed in both BOOT and RUN.

Test Plan:
- Boot and hold:
  - Stimulus: deassert reset, then loader writes 0x00500093 to addr 3 and 0x00A00113 to addr 6, with fetch_req = 1 throughout.
  - Required: fetch_stall = 1 every cycle; mem_we pulses twice with the correct addr and data; fetch_valid stays 0.
- Boot exit and fetch:
  - Stimulus: pulse boot_done, then fetch addr 3, then addr 6.
  - Required: fetch_valid one cycle after each grant; fetch_data = 0x00500093, then 0x00A00113.
- Starvation:
  - Stimulus: fetch_req and ld_req (read addr 6) held high continuously, STARVE_LIMIT = 4.
  - Required: 4 fetch grants, then ld_gnt = 1 with fetch_stall = 1 on the 5th cycle; ld_rdata = 0x00A00113 with ld_rvalid on the 6th; pattern repeats.
- Loader-only in RUN:
  - Stimulus: ld_req read of addr 3 with fetch_req = 0.
  - Required: immediate grant, fetch_stall = 0, ld_rvalid next cycle with 0x00500093.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as a granted fetch.
  - Required: next cycle fetch_valid = 0, fetch_data = 0, state BOOT (fetch_stall = 1).
- Write protect (macro defined):
  - Stimulus: loader writes 0xFFFFFFFF to addr 3 in RUN.
  - Required: mem_we = 0, ld_err = 1 next cycle; a subsequent fetch of addr 3 returns 0x00500093.
